// File: rtl/vc_sync_fifo.sv
// vc_sync_fifo: single-clock multi-virtual-channel flit buffer for a router input port.
// All VCs share one storage array addressed {vc, ptr}; each VC keeps its own pointers,
// occupancy count, registered full/empty/threshold flags. Sticky error flags record
// writes dropped on a full VC and reads ignored on an empty VC.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/wr_vc/wr_data  write request, target VC, flit
//   rd_en/rd_vc          read request, source VC
//   rd_data/rd_valid     registered read data, valid one cycle after an accepted read
//   full/almost_full     per-VC full and count >= AF_LEVEL
//   empty/almost_empty   per-VC empty and count <= AE_LEVEL
//   count                per-VC occupancy, VC v in bits [v*CW +: CW]
//   ovf_err/udf_err      sticky overflow / underflow
module vc_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned VC_NUM     = 2,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2,
    localparam int unsigned VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int unsigned CW  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [VCW-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [VCW-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic [VC_NUM-1:0]      full,
    output logic [VC_NUM-1:0]      almost_full,
    output logic [VC_NUM-1:0]      empty,
    output logic [VC_NUM-1:0]      almost_empty,
    output logic [VC_NUM*CW-1:0]   count,
    output logic                   ovf_err,
    output logic                   udf_err
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned AW  = VCW + PW;
    localparam int unsigned MEM = 1 << AW;

    logic [DATA_WIDTH-1:0] r_mem [MEM];
    logic [PW-1:0]         r_wr_ptr [VC_NUM];
    logic [PW-1:0]         r_rd_ptr [VC_NUM];
    logic [CW-1:0]         r_count  [VC_NUM];
    logic [CW-1:0]         w_cnt_nxt [VC_NUM];

    logic [VC_NUM-1:0]     r_full, r_af, r_empty, r_ae;
    logic [VC_NUM-1:0]     w_wr_hit, w_rd_hit, w_wr_acc, w_rd_acc;
    logic [AW-1:0]         w_wr_addr, w_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid, r_ovf, r_udf;

    // Request decode; a VC index >= VC_NUM matches no VC and is silently ignored.
    // Acceptance uses start-of-cycle flags only, so there is no write-to-read bypass.
    always_comb begin
        w_wr_hit  = '0;
        w_rd_hit  = '0;
        w_wr_acc  = '0;
        w_rd_acc  = '0;
        w_wr_addr = '0;
        w_rd_addr = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_wr_hit[v] = wr_en && (wr_vc == VCW'(v));
            w_rd_hit[v] = rd_en && (rd_vc == VCW'(v));
            w_wr_acc[v] = w_wr_hit[v] && !r_full[v];
            w_rd_acc[v] = w_rd_hit[v] && !r_empty[v];
            if (w_wr_hit[v]) w_wr_addr = {VCW'(v), r_wr_ptr[v]};
            if (w_rd_hit[v]) w_rd_addr = {VCW'(v), r_rd_ptr[v]};
            case ({w_wr_acc[v], w_rd_acc[v]})
                2'b10:   w_cnt_nxt[v] = r_count[v] + CW'(1);
                2'b01:   w_cnt_nxt[v] = r_count[v] - CW'(1);
                default: w_cnt_nxt[v] = r_count[v];
            endcase
        end
    end

    // Flit storage; not reset, stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (|w_wr_acc) r_mem[w_wr_addr] <= wr_data;
    end

    // Pointers, counts, flags and read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_full     <= '0;
            r_af       <= '0;
            r_empty    <= '1;
            r_ae       <= '1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_wr_acc[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
                if (w_rd_acc[v]) r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
                r_count[v] <= w_cnt_nxt[v];
                r_full[v]  <= (w_cnt_nxt[v] == CW'(DEPTH));
                r_empty[v] <= (w_cnt_nxt[v] == '0);
                r_af[v]    <= (w_cnt_nxt[v] >= CW'(AF_LEVEL));
                r_ae[v]    <= (w_cnt_nxt[v] <= CW'(AE_LEVEL));
            end
            r_rd_valid <= |w_rd_acc;
            if (|w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
            r_ovf <= r_ovf | (|(w_wr_hit & r_full));
            r_udf <= r_udf | (|(w_rd_hit & r_empty));
        end
    end

    // Pack per-VC counts onto the flat output bus.
    always_comb begin
        count = '0;
        for (int v = 0; v < VC_NUM; v++) count[v*CW +: CW] = r_count[v];
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign empty        = r_empty;
    assign almost_empty = r_ae;
    assign ovf_err      = r_ovf;
    assign udf_err      = r_udf;

endmodule

// File: tb/tb_vc_sync_fifo.sv
// Testbench for vc_sync_fifo (32-bit, depth 8, 2 VCs, AF=6, AE=2).
// Driver issues per-cycle requests and keeps a per-VC reference queue; expected read
// data goes into a scoreboard queue that an independent monitor drains on rd_valid.
module tb_vc_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned VCN   = 2;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;
    localparam int unsigned VCW   = 1;
    localparam int unsigned CW    = 4;

    logic              clk, rst;
    logic              wr_en, rd_en;
    logic [VCW-1:0]    wr_vc, rd_vc;
    logic [DW-1:0]     wr_data, rd_data;
    logic              rd_valid, ovf_err, udf_err;
    logic [VCN-1:0]    full, almost_full, empty, almost_empty;
    logic [VCN*CW-1:0] count;

    vc_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .VC_NUM(VCN),
                   .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .almost_full(almost_full),
        .empty(empty), .almost_empty(almost_empty),
        .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_q[$];
    logic          e_ovf = 1'b0;
    logic          e_udf = 1'b0;
    logic [DW-1:0] last_rd = '0;

    function automatic int qsize(input logic [VCW-1:0] v);
        return (v == 1'b0) ? q0.size() : q1.size();
    endfunction

    // Monitor: consumes one expected flit per rd_valid; rd_data must hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_rd = '0;
        end else begin
            checks++;
            if (rd_valid && exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 data=%08h, no read expected", rd_data);
            end else if (!rd_valid && exp_q.size() != 0) begin
                errors++;
                $display("FAIL rd_missing: rd_valid=0, required data %08h", exp_q[0]);
                void'(exp_q.pop_front());
            end else if (rd_valid) begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %08h required %08h", rd_data, e);
                end
            end else if (rd_data !== last_rd) begin
                errors++;
                $display("FAIL rd_hold: got %08h required %08h", rd_data, last_rd);
            end
            last_rd = rd_data;
        end
    end

    task automatic check_flags(input string tag);
        logic [VCN*CW-1:0] ec;
        logic [VCN-1:0] ef, eaf, ee, eae;
        logic [VCN*CW+4*VCN+1:0] got, req;
        int s;
        ec = '0; ef = '0; eaf = '0; ee = '0; eae = '0;
        for (int v = 0; v < VCN; v++) begin
            s = qsize(VCW'(v));
            ec[v*CW +: CW] = CW'(s);
            ef[v]  = (s == DEPTH);
            eaf[v] = (s >= AF);
            ee[v]  = (s == 0);
            eae[v] = (s <= AE);
        end
        got = {count, full, almost_full, empty, almost_empty, ovf_err, udf_err};
        req = {ec, ef, eaf, ee, eae, e_ovf, e_udf};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL flags_%s: got cnt=%h f=%b af=%b e=%b ae=%b ovf=%b udf=%b required cnt=%h f=%b af=%b e=%b ae=%b ovf=%b udf=%b",
                     tag, count, full, almost_full, empty, almost_empty, ovf_err, udf_err,
                     ec, ef, eaf, ee, eae, e_ovf, e_udf);
        end
    endtask

    // One clock of stimulus; reference model advances at the edge.
    task automatic cyc(input logic we, input logic [VCW-1:0] wv, input logic [DW-1:0] wd,
                       input logic re, input logic [VCW-1:0] rv, input string tag);
        logic wacc, racc;
        wr_en = we; wr_vc = wv; wr_data = wd;
        rd_en = re; rd_vc = rv;
        wacc = we && (qsize(wv) < DEPTH);
        racc = re && (qsize(rv) > 0);
        if (we && !wacc) e_ovf = 1'b1;
        if (re && !racc) e_udf = 1'b1;
        @(posedge clk);
        if (racc) exp_q.push_back((rv == 1'b0) ? q0.pop_front() : q1.pop_front());
        if (wacc) begin
            if (wv == 1'b0) q0.push_back(wd); else q1.push_back(wd);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check_flags(tag);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_vc = '0; rd_vc = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_flags("reset");

        // 1: reset mid-traffic with VC0 holding 5 flits and a read in flight
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, DW'(32'h50 + i), 1'b0, 1'b0, "t1_fill");
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "t1_read");
        #1 rst = 1'b1;
        #1;
        q0.delete(); q1.delete(); exp_q.delete();
        e_ovf = 1'b0; e_udf = 1'b0;
        checks++;
        if (count !== '0 || empty !== 2'b11 || rd_valid !== 1'b0 || ovf_err || udf_err) begin
            errors++;
            $display("FAIL async_reset: cnt=%h empty=%b rd_valid=%b ovf=%b udf=%b required 0/11/0/0/0",
                     count, empty, rd_valid, ovf_err, udf_err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        check_flags("t1_after");

        // 2: fill VC0 with 1..8, then overflow attempt
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0, 1'b0, "t2_fill");
        cyc(1'b1, 1'b0, 32'h99, 1'b0, 1'b0, "t2_ovf");

        // 3: drain VC0 back-to-back, then underflow attempt
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "t3_drain");
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "t3_udf");

        // 4: write VC1 while reading VC0
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(32'h10 + i), 1'b0, 1'b0, "t4_pre");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, DW'(32'hA0 + i), 1'b1, 1'b0, "t4_mix");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, "t4_vc1");

        // 5: VC0 at 4 entries, simultaneous write+read for 20 cycles
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(32'h200 + i), 1'b0, 1'b0, "t5_pre");
        for (int i = 4; i < 24; i++) cyc(1'b1, 1'b0, DW'(32'h200 + i), 1'b1, 1'b0, "t5_wr_rd");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "t5_drain");

        // 6: random traffic on both VCs
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom), $urandom,
                1'($urandom_range(0, 99) < 50), 1'($urandom), "t6_rand");
        for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, 1'($urandom), "t6_drain");

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
